lab3_selftest: RTL and testbench

Sequential built-in self-test driver/checker for the lab 3 combinational gate network (inputs a, b, c; outputs x, y). It drives all eight input vectors onto the network, waits a programmable settle time per vector, and compares the returned x/y against the golden function. It reports error count, first failing vector, and pass/fail. It sits on the opposite side of the gate network's pins: it drives the network's inputs and receives its outputs.

---
 rtl/lab3_selftest.sv | 113 +++++++++++
 tb/tb_lab3_selftest.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_selftest.sv
// Built-in self-test driver/checker for the lab 3 gate network (x = ~c ^ (a | b), y = a & b).
// Sweeps all eight {a,b,c} vectors, holds each for a settle time, and tallies mismatches.
module lab3_selftest #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_x,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] vec;
  logic [3:0] settle_cnt;
  logic       settle_last;
  logic       start_run;
  logic       do_check;
  logic       x_exp;
  logic       y_exp;
  logic       mismatch;
  logic [3:0] err_next;

  assign settle_last = (settle_cnt == 4'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (settle_last) state_next = CHECK;
      CHECK:   state_next = (vec == 3'd7) ? IDLE : SETTLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_run = (state == IDLE) && start;
    do_check  = (state == CHECK);
    busy      = (state != IDLE);
  end

  // Golden response for the vector currently on the pins.
  assign x_exp    = ~vec[0] ^ (vec[2] | vec[1]);
  assign y_exp    = vec[2] & vec[1];
  assign mismatch = (dut_x != x_exp) || (dut_y != y_exp);
  assign err_next = err_count + {3'b000, mismatch};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec              <= 3'd0;
      settle_cnt       <= 4'd0;
      err_count        <= 4'd0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      if (start_run) begin
        vec              <= 3'd0;
        settle_cnt       <= 4'd0;
        err_count        <= 4'd0;
        first_fail_vec   <= 3'd0;
        first_fail_valid <= 1'b0;
        done             <= 1'b0;
        pass             <= 1'b0;
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_last ? 4'd0 : settle_cnt + 4'd1;
      end
      if (do_check) begin
        err_count <= err_next;
        if (mismatch && !first_fail_valid) begin
          first_fail_vec   <= vec;
          first_fail_valid <= 1'b1;
        end
        // Pass must reflect this last compare, so it uses the updated count.
        if (vec == 3'd7) begin
          done <= 1'b1;
          pass <= (err_next == 4'd0);
          vec  <= 3'd0;
        end else begin
          vec <= vec + 3'd1;
        end
      end
    end
  end

  assign dut_a = vec[2];
  assign dut_b = vec[1];
  assign dut_c = vec[0];

endmodule

// File: tb/tb_lab3_selftest.sv
// Bench for lab3_selftest: a faultable network model drives one S=2 instance and a golden
// network drives an S=1 instance; expected results come from a per-vector fault count.
module tb_lab3_selftest;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start1;
  logic [7:0] x_mask;
  logic [7:0] y_mask;
  logic       y_stuck;
  int         checks;
  int         errors;

  logic       dut_a, dut_b, dut_c, dut_x, dut_y;
  logic       busy, done, pass, first_fail_valid;
  logic [3:0] err_count;
  logic [2:0] first_fail_vec;

  logic       a1, b1, c1, x1, y1;
  logic       busy1, done1, pass1, ffv1;
  logic [3:0] err1;
  logic [2:0] ffvec1;

  logic [2:0] net_vec;

  lab3_selftest #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_x(dut_x), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );

  lab3_selftest #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_x(x1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffvec1), .first_fail_valid(ffv1)
  );

  // Network model with per-vector output inversions and a y stuck-at-0 option.
  assign net_vec = {dut_a, dut_b, dut_c};
  assign dut_x   = (~dut_c ^ (dut_a | dut_b)) ^ x_mask[net_vec];
  assign dut_y   = y_stuck ? 1'b0 : ((dut_a & dut_b) ^ y_mask[net_vec]);
  assign x1      = ~c1 ^ (a1 | b1);
  assign y1      = a1 & b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    start1 = 1'b1;
    tick();
    checks++;
    if ({dut_a, dut_b, dut_c, busy, done, pass, err_count, first_fail_vec, first_fail_valid} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, expected all zero", {dut_a, dut_b, dut_c, busy, done, pass, err_count, first_fail_vec, first_fail_valid});
    end
    checks++;
    if ({a1, b1, c1, busy1, done1, pass1, err1, ffvec1, ffv1} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_s1: got %b, expected all zero", {a1, b1, c1, busy1, done1, pass1, err1, ffvec1, ffv1});
    end
    start = 1'b0;
    start1 = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  // Runs one S=2 sweep, checking the pin sequence cycle by cycle and the final results.
  task automatic run_check(input string name, input logic [7:0] xm, input logic [7:0] ym,
                           input logic ys, input int restart_at, input int exp_err,
                           input logic [2:0] exp_first, input logic exp_valid);
    x_mask = xm;
    y_mask = ym;
    y_stuck = ys;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || err_count !== 4'd0 || first_fail_valid !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s start_clear: got done=%b err=%0d ffv=%b pass=%b, expected 0 0 0 0", name, done, err_count, first_fail_valid, pass);
    end
    for (int j = 0; j < 24; j++) begin
      if (j > 0) tick();
      if (j == restart_at) start = 1'b0;
      checks++;
      if ({dut_a, dut_b, dut_c} !== 3'(j / 3) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s seq edge k+%0d: got vec=%0d busy=%b done=%b, expected vec=%0d busy=1 done=0", name, j, {dut_a, dut_b, dut_c}, busy, done, j / 3);
      end
      if (j + 1 == restart_at) start = 1'b1;
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== (exp_err == 0) || err_count !== 4'(exp_err)) begin
      errors++;
      $display("[TB] FAIL %s result: got done=%b busy=%b pass=%b err=%0d, expected 1 0 %b %0d", name, done, busy, pass, err_count, exp_err == 0, exp_err);
    end
    checks++;
    if (first_fail_valid !== exp_valid || first_fail_vec !== exp_first) begin
      errors++;
      $display("[TB] FAIL %s first_fail: got valid=%b vec=%b, expected %b %b", name, first_fail_valid, first_fail_vec, exp_valid, exp_first);
    end
    checks++;
    if ({dut_a, dut_b, dut_c} !== 3'd0) begin
      errors++;
      $display("[TB] FAIL %s pins_after: got %b, expected 000", name, {dut_a, dut_b, dut_c});
    end
  endtask

  task automatic test_golden();
    run_check("golden", 8'h00, 8'h00, 1'b0, -1, 0, 3'd0, 1'b0);
  endtask

  task automatic test_y_stuck();
    run_check("y_stuck", 8'h00, 8'h00, 1'b1, -1, 2, 3'b110, 1'b1);
  endtask

  task automatic test_x_inverted();
    run_check("x_inverted", 8'hFF, 8'h00, 1'b0, -1, 8, 3'b000, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_check("ignored_start", 8'hFF, 8'h00, 1'b0, 10, 8, 3'b000, 1'b1);
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || err_count !== 4'd8 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL results_hold: got done=%b err=%0d busy=%b, expected 1 8 0", done, err_count, busy);
    end
    run_check("restart", 8'h00, 8'h00, 1'b0, -1, 0, 3'd0, 1'b0);
  endtask

  task automatic test_mid_reset();
    x_mask = 8'h0F;
    y_mask = 8'h00;
    y_stuck = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 12; j++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({dut_a, dut_b, dut_c, busy, done, pass, err_count, first_fail_vec, first_fail_valid} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %b, expected all zero", {dut_a, dut_b, dut_c, busy, done, pass, err_count, first_fail_vec, first_fail_valid});
    end
    for (int j = 0; j < 30; j++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {dut_a, dut_b, dut_c} !== 3'd0) begin
        errors++;
        $display("[TB] FAIL mid_reset_idle cycle %0d: got busy=%b done=%b vec=%0d, expected 0 0 0", j, busy, done, {dut_a, dut_b, dut_c});
      end
    end
  endtask

  task automatic test_settle_one();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) tick();
      checks++;
      if ({a1, b1, c1} !== 3'(j / 2) || busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL s1 seq edge k+%0d: got vec=%0d busy=%b done=%b, expected vec=%0d busy=1 done=0", j, {a1, b1, c1}, busy1, done1, j / 2);
      end
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || pass1 !== 1'b1 || err1 !== 4'd0 || ffv1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL s1 result: got done=%b busy=%b pass=%b err=%0d ffv=%b, expected 1 0 1 0 0", done1, busy1, pass1, err1, ffv1);
    end
  endtask

  // Reference: a vector fails when either output is disturbed; first fail is the lowest such vector.
  task automatic test_random_faults();
    for (int n = 0; n < 8; n++) begin
      logic [7:0] xm;
      logic [7:0] ym;
      int         exp_err;
      logic [2:0] exp_first;
      logic       exp_valid;
      xm = 8'($urandom);
      ym = 8'($urandom);
      if (n % 2 == 0) begin
        xm = xm & 8'($urandom) & 8'($urandom);
        ym = ym & 8'($urandom) & 8'($urandom);
      end
      if (n == 3) begin
        xm = 8'h00;
        ym = 8'h00;
      end
      exp_err = 0;
      exp_first = 3'd0;
      exp_valid = 1'b0;
      for (int v = 0; v < 8; v++) begin
        if (xm[v] || ym[v]) begin
          exp_err++;
          if (!exp_valid) begin
            exp_first = 3'(v);
            exp_valid = 1'b1;
          end
        end
      end
      run_check("random", xm, ym, 1'b0, -1, exp_err, exp_first, exp_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    x_mask = 8'h00;
    y_mask = 8'h00;
    y_stuck = 1'b0;
    tick();
    test_reset();
    test_golden();
    test_y_stuck();
    test_x_inverted();
    test_back_to_back();
    test_mid_reset();
    test_settle_one();
    test_random_faults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
